lcd_timing_gen: RTL and testbench

Generates the RGB-LCD raster timing that drives the panel and the pixel pattern generators. It produces a horizontal and a vertical position counter (PixelCount, LineCount), plus active-low HSYNC/VSYNC, DE and active-area coordinates. Pattern blocks consume PixelCount/LineCount and return LCD_R/G/B. It sits between the pixel-clock PLL output and the panel pins on the Tang Nano 9K LCD board.

---
 rtl/lcd_timing_gen.sv | 130 +++++++++++++
 tb/tb_lcd_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// RGB-LCD raster timing generator: pixel/line counters with registered sync,
// data-enable, active-area coordinate and start-of-line/frame decodes.
module lcd_timing_gen #(
  parameter int H_PULSE      = 1,
  parameter int H_BACKPORCH  = 46,
  parameter int H_ACTIVE     = 800,
  parameter int H_FRONTPORCH = 210,
  parameter int V_PULSE      = 1,
  parameter int V_BACKPORCH  = 23,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONTPORCH = 22
) (
  input  logic        PixelClk,
  input  logic        Reset,
  input  logic        Run,
  output logic [15:0] PixelCount,
  output logic [15:0] LineCount,
  output logic [15:0] ActiveX,
  output logic [15:0] ActiveY,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DE,
  output logic        FrameStart,
  output logic        LineStart
);

  localparam int H_TOTAL_I = H_PULSE + H_BACKPORCH + H_ACTIVE + H_FRONTPORCH;
  localparam int V_TOTAL_I = V_PULSE + V_BACKPORCH + V_ACTIVE + V_FRONTPORCH;

  if (H_TOTAL_I > 65535 || V_TOTAL_I > 65535) begin : g_sum_chk
    $error("lcd_timing_gen: parameter sums must stay below 65536");
  end
  if (H_PULSE < 1 || H_ACTIVE < 1 || V_PULSE < 1 || V_ACTIVE < 1) begin : g_zero_chk
    $error("lcd_timing_gen: pulse and active widths must be non-zero");
  end
  if (H_BACKPORCH < 0 || H_FRONTPORCH < 0 || V_BACKPORCH < 0 || V_FRONTPORCH < 0) begin : g_neg_chk
    $error("lcd_timing_gen: porch widths must not be negative");
  end

  localparam logic [15:0] H_LAST      = 16'(H_TOTAL_I - 1);
  localparam logic [15:0] V_LAST      = 16'(V_TOTAL_I - 1);
  localparam logic [15:0] H_SYNC_END  = 16'(H_PULSE);
  localparam logic [15:0] V_SYNC_END  = 16'(V_PULSE);
  localparam logic [15:0] H_ACT_START = 16'(H_PULSE + H_BACKPORCH);
  localparam logic [15:0] H_ACT_END   = 16'(H_PULSE + H_BACKPORCH + H_ACTIVE);
  localparam logic [15:0] V_ACT_START = 16'(V_PULSE + V_BACKPORCH);
  localparam logic [15:0] V_ACT_END   = 16'(V_PULSE + V_BACKPORCH + V_ACTIVE);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_nxt;
  logic [15:0] h_p0, v_p0, ax_p0, ay_p0;
  logic        vld_p0, hs_p0, vs_p0, de_p0, fs_p0, ls_p0;
  logic        h_in_p0, v_in_p0;

  // Stage p0: next raster position, then decodes of that same position so the
  // registered counts and decodes always describe one pixel.
  always_comb begin
    state_nxt = state_q;
    h_p0      = '0;
    v_p0      = '0;
    vld_p0    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          state_nxt = SCAN;
          vld_p0    = 1'b1;
        end
      end
      SCAN: begin
        vld_p0 = 1'b1;
        if (PixelCount == H_LAST) begin
          if (LineCount == V_LAST) begin
            // Run is honoured only here, so a mid-frame drop finishes the frame.
            if (!Run) begin
              state_nxt = IDLE;
              vld_p0    = 1'b0;
            end
          end else begin
            v_p0 = LineCount + 16'd1;
          end
        end else begin
          h_p0 = PixelCount + 16'd1;
          v_p0 = LineCount;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    h_in_p0 = (h_p0 >= H_ACT_START) && (h_p0 < H_ACT_END);
    v_in_p0 = (v_p0 >= V_ACT_START) && (v_p0 < V_ACT_END);
    hs_p0   = !(vld_p0 && (h_p0 < H_SYNC_END));
    vs_p0   = !(vld_p0 && (v_p0 < V_SYNC_END));
    de_p0   = vld_p0 && h_in_p0 && v_in_p0;
    ls_p0   = vld_p0 && (h_p0 == 16'd0);
    fs_p0   = ls_p0 && (v_p0 == 16'd0);
    ax_p0   = de_p0 ? (h_p0 - H_ACT_START) : 16'd0;
    ay_p0   = de_p0 ? (v_p0 - V_ACT_START) : 16'd0;
  end

  // Stage p1: output registers, all loaded on the same edge.
  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      state_q    <= IDLE;
      PixelCount <= '0;
      LineCount  <= '0;
      ActiveX    <= '0;
      ActiveY    <= '0;
      LCD_HSYNC  <= 1'b1;
      LCD_VSYNC  <= 1'b1;
      LCD_DE     <= 1'b0;
      FrameStart <= 1'b0;
      LineStart  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      PixelCount <= h_p0;
      LineCount  <= v_p0;
      ActiveX    <= ax_p0;
      ActiveY    <= ay_p0;
      LCD_HSYNC  <= hs_p0;
      LCD_VSYNC  <= vs_p0;
      LCD_DE     <= de_p0;
      FrameStart <= fs_p0;
      LineStart  <= ls_p0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: default-timing instance for start/edge/reset behaviour and a
// tiny-raster instance checked cycle by cycle over whole frames.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default-parameter instance
  logic        rst_d, run_d;
  logic [15:0] pc_d, lc_d, ax_d, ay_d;
  logic        hs_d, vs_d, de_d, fs_d, ls_d;

  lcd_timing_gen u_def (
    .PixelClk(clk), .Reset(rst_d), .Run(run_d),
    .PixelCount(pc_d), .LineCount(lc_d), .ActiveX(ax_d), .ActiveY(ay_d),
    .LCD_HSYNC(hs_d), .LCD_VSYNC(vs_d), .LCD_DE(de_d),
    .FrameStart(fs_d), .LineStart(ls_d)
  );

  // Small raster: H_TOTAL=7, V_TOTAL=4, active h=2..5, v=1..2
  logic        rst_s, run_s;
  logic [15:0] pc_s, lc_s, ax_s, ay_s;
  logic        hs_s, vs_s, de_s, fs_s, ls_s;

  lcd_timing_gen #(
    .H_PULSE(2), .H_BACKPORCH(0), .H_ACTIVE(4), .H_FRONTPORCH(1),
    .V_PULSE(1), .V_BACKPORCH(0), .V_ACTIVE(2), .V_FRONTPORCH(1)
  ) u_sml (
    .PixelClk(clk), .Reset(rst_s), .Run(run_s),
    .PixelCount(pc_s), .LineCount(lc_s), .ActiveX(ax_s), .ActiveY(ay_s),
    .LCD_HSYNC(hs_s), .LCD_VSYNC(vs_s), .LCD_DE(de_s),
    .FrameStart(fs_s), .LineStart(ls_s)
  );

  task automatic test_reset();
    rst_d = 1'b1; run_d = 1'b1;
    rst_s = 1'b1; run_s = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({pc_d, lc_d} !== 32'd0) begin
      $display("FAIL reset_counts: got h=%0d v=%0d, want 0 0", pc_d, lc_d); n_err++;
    end
    n_cmp++;
    if ({ax_d, ay_d} !== 32'd0) begin
      $display("FAIL reset_active: got x=%0d y=%0d, want 0 0", ax_d, ay_d); n_err++;
    end
    n_cmp++;
    if ({hs_d, vs_d, de_d, fs_d, ls_d} !== 5'b11000) begin
      $display("FAIL reset_flags: got hs/vs/de/fs/ls=%b, want 11000", {hs_d, vs_d, de_d, fs_d, ls_d}); n_err++;
    end
  endtask

  task automatic test_run_start();
    rst_d = 1'b0; run_d = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pc_d, lc_d} !== 32'd0 || {hs_d, vs_d, de_d, fs_d, ls_d} !== 5'b00011) begin
      $display("FAIL start_first: got h=%0d v=%0d hs/vs/de/fs/ls=%b, want 0 0 00011",
               pc_d, lc_d, {hs_d, vs_d, de_d, fs_d, ls_d}); n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd1 || {hs_d, vs_d, fs_d, ls_d} !== 4'b1000) begin
      $display("FAIL start_h1: got h=%0d hs/vs/fs/ls=%b, want 1 1000", pc_d, {hs_d, vs_d, fs_d, ls_d}); n_err++;
    end
    repeat (1055) @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd1056 || lc_d !== 16'd0) begin
      $display("FAIL line_end: got h=%0d v=%0d, want 1056 0", pc_d, lc_d); n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd0 || lc_d !== 16'd1 || {hs_d, vs_d, fs_d, ls_d} !== 4'b0101) begin
      $display("FAIL line_wrap: got h=%0d v=%0d hs/vs/fs/ls=%b, want 0 1 0101",
               pc_d, lc_d, {hs_d, vs_d, fs_d, ls_d}); n_err++;
    end
  endtask

  task automatic test_active_edges();
    repeat (23 * 1057 + 46) @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd46 || lc_d !== 16'd24 || de_d !== 1'b0 || ax_d !== 16'd0) begin
      $display("FAIL edge_46_24: got h=%0d v=%0d de=%b x=%0d, want 46 24 0 0", pc_d, lc_d, de_d, ax_d); n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd47 || de_d !== 1'b1 || ax_d !== 16'd0 || ay_d !== 16'd0) begin
      $display("FAIL edge_47_24: got h=%0d de=%b x=%0d y=%0d, want 47 1 0 0", pc_d, de_d, ax_d, ay_d); n_err++;
    end
    repeat (453) @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd500 || lc_d !== 16'd24 || de_d !== 1'b1 || ax_d !== 16'd453 || vs_d !== 1'b1) begin
      $display("FAIL mid_24: got h=%0d v=%0d de=%b x=%0d vs=%b, want 500 24 1 453 1",
               pc_d, lc_d, de_d, ax_d, vs_d); n_err++;
    end
  endtask

  task automatic test_reset_midframe();
    rst_d = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pc_d, lc_d, ax_d, ay_d} !== 64'd0 || {hs_d, vs_d, de_d, fs_d, ls_d} !== 5'b11000) begin
      $display("FAIL reset_mid: got h=%0d v=%0d x=%0d y=%0d flags=%b, want 0 0 0 0 11000",
               pc_d, lc_d, ax_d, ay_d, {hs_d, vs_d, de_d, fs_d, ls_d}); n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (pc_d !== 16'd0 || fs_d !== 1'b0) begin
      $display("FAIL reset_hold: got h=%0d fs=%b with Run=1, want 0 0", pc_d, fs_d); n_err++;
    end
    rst_d = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fs_d, ls_d, hs_d, vs_d} !== 4'b1100) begin
      $display("FAIL restart: got fs/ls/hs/vs=%b, want 1100", {fs_d, ls_d, hs_d, vs_d}); n_err++;
    end
  endtask

  task automatic test_small_frame();
    int mh, mv, prev_fs, ls_cnt, de_cnt, vs_cnt;
    logic e_hs, e_vs, e_de, e_ls, e_fs;
    int e_ax, e_ay;
    mh = 0; mv = 0; prev_fs = 0; ls_cnt = 0; de_cnt = 0; vs_cnt = 0;
    rst_s = 1'b0; run_s = 1'b1;
    for (int i = 0; i < 84; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (mh == 6) begin
          mh = 0;
          mv = (mv == 3) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      e_hs = !(mh <= 1);
      e_vs = !(mv == 0);
      e_de = (mh >= 2 && mh <= 5 && mv >= 1 && mv <= 2);
      e_ls = (mh == 0);
      e_fs = (mh == 0 && mv == 0);
      e_ax = e_de ? mh - 2 : 0;
      e_ay = e_de ? mv - 1 : 0;
      n_cmp++;
      if (pc_s !== 16'(mh) || lc_s !== 16'(mv)) begin
        $display("FAIL sml_count[%0d]: got h=%0d v=%0d, want %0d %0d", i, pc_s, lc_s, mh, mv); n_err++;
      end
      n_cmp++;
      if ({hs_s, vs_s, de_s, fs_s, ls_s} !== {e_hs, e_vs, e_de, e_fs, e_ls}) begin
        $display("FAIL sml_flags[%0d]: got hs/vs/de/fs/ls=%b, want %b", i,
                 {hs_s, vs_s, de_s, fs_s, ls_s}, {e_hs, e_vs, e_de, e_fs, e_ls}); n_err++;
      end
      n_cmp++;
      if (ax_s !== 16'(e_ax) || ay_s !== 16'(e_ay)) begin
        $display("FAIL sml_active[%0d]: got x=%0d y=%0d, want %0d %0d", i, ax_s, ay_s, e_ax, e_ay); n_err++;
      end
      if (fs_s === 1'b1 && i > 0) begin
        n_cmp++;
        if (i - prev_fs != 28 || ls_cnt != 4 || de_cnt != 8 || vs_cnt != 7) begin
          $display("FAIL sml_frame: got period=%0d lines=%0d de=%0d vslow=%0d, want 28 4 8 7",
                   i - prev_fs, ls_cnt, de_cnt, vs_cnt); n_err++;
        end
        prev_fs = i; ls_cnt = 0; de_cnt = 0; vs_cnt = 0;
      end
      if (ls_s === 1'b1) ls_cnt++;
      if (de_s === 1'b1) de_cnt++;
      if (vs_s === 1'b0) vs_cnt++;
    end
  endtask

  task automatic test_run_drop();
    // Small instance is at (6,3); one more cycle starts frame 4.
    repeat (8) @(negedge clk);
    n_cmp++;
    if (pc_s !== 16'd0 || lc_s !== 16'd1) begin
      $display("FAIL drop_pos: got h=%0d v=%0d, want 0 1", pc_s, lc_s); n_err++;
    end
    run_s = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (pc_s !== 16'd6 || lc_s !== 16'd3 || vs_s !== 1'b1) begin
      $display("FAIL drop_finish: got h=%0d v=%0d vs=%b, want 6 3 1", pc_s, lc_s, vs_s); n_err++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({pc_s, lc_s} !== 32'd0 || {hs_s, vs_s, de_s, fs_s, ls_s} !== 5'b11000) begin
        $display("FAIL drop_idle[%0d]: got h=%0d v=%0d flags=%b, want 0 0 11000",
                 k, pc_s, lc_s, {hs_s, vs_s, de_s, fs_s, ls_s}); n_err++;
      end
    end
    run_s = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pc_s !== 16'd0 || {hs_s, vs_s, fs_s, ls_s} !== 4'b0011) begin
      $display("FAIL rerun_first: got h=%0d hs/vs/fs/ls=%b, want 0 0011", pc_s, {hs_s, vs_s, fs_s, ls_s}); n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (pc_s !== 16'd1 || hs_s !== 1'b0 || fs_s !== 1'b0) begin
      $display("FAIL rerun_h1: got h=%0d hs=%b fs=%b, want 1 0 0", pc_s, hs_s, fs_s); n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (pc_s !== 16'd2 || hs_s !== 1'b1 || de_s !== 1'b0) begin
      $display("FAIL rerun_h2: got h=%0d hs=%b de=%b, want 2 1 0", pc_s, hs_s, de_s); n_err++;
    end
  endtask

  initial begin
    rst_d = 1'b1; run_d = 1'b0;
    rst_s = 1'b1; run_s = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_start();
    test_active_edges();
    test_reset_midframe();
    rst_s = 1'b1; run_s = 1'b0;
    @(negedge clk);
    test_small_frame();
    test_run_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
